wordle_scorer: RTL and testbench

- Sequential scorer for one 5-letter guess against the hidden answer. Produces per-letter colour codes and a win flag.
- Sits between the guess-entry state machine, which holds the five letter registers and the random word, and the display logic.
- The display logic copies the colours into the colour array row for the current guess.
- Applies standard duplicate-letter rules: exact matches consume answer letters first; yellows consume the remaining letters, lowest index first.

---
 rtl/wordle_scorer_pkg.sv | 27 ++
 rtl/wordle_letter_match.sv | 23 ++
 rtl/wordle_scorer.sv | 113 +++++++++++
 tb/tb_wordle_scorer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/wordle_scorer_pkg.sv
// Shared definitions for the wordle scorer: word geometry, colour codes and FSM states.
// Display logic and the guess-entry FSM import the same colour codes.
package wordle_scorer_pkg;

    localparam int unsigned N_LETTERS = 5;
    localparam int unsigned LETTER_W  = 8;
    localparam int unsigned WORD_W    = N_LETTERS * LETTER_W;
    localparam int unsigned COLOR_W   = 3;

    localparam logic [COLOR_W-1:0] COLOR_GREEN  = 3'b010;
    localparam logic [COLOR_W-1:0] COLOR_YELLOW = 3'b110;
    localparam logic [COLOR_W-1:0] COLOR_MISS   = 3'b111;

    typedef enum logic [1:0] {
        StIdle,
        StGreen,
        StYellow,
        StDone
    } state_e;

    // Letter 0 is the leftmost character, held in the top byte of the word.
    function automatic logic [LETTER_W-1:0] letter_at(input logic [WORD_W-1:0] word,
                                                      input logic [2:0] idx);
        return word[(WORD_W - 1) - (LETTER_W * idx) -: LETTER_W];
    endfunction

endpackage

// File: rtl/wordle_letter_match.sv
// Finds the lowest-index answer letter equal to i_letter that has not yet been consumed.
module wordle_letter_match
    import wordle_scorer_pkg::*;
(
    input  logic [LETTER_W-1:0]  i_letter,
    input  logic [WORD_W-1:0]    i_answer,
    input  logic [N_LETTERS-1:0] i_consumed,
    output logic                 o_found,
    output logic [N_LETTERS-1:0] o_match_oh
);

    always_comb begin
        o_found    = 1'b0;
        o_match_oh = '0;
        for (int j = 0; j < N_LETTERS; j++) begin
            if (!o_found && !i_consumed[j] && (letter_at(i_answer, 3'(j)) == i_letter)) begin
                o_found       = 1'b1;
                o_match_oh[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wordle_scorer.sv
// Sequential scorer: one green pass, then one yellow/miss decision per letter, then publish.
// Outputs hold the last scored result until the next publish or reset.
module wordle_scorer
    import wordle_scorer_pkg::*;
(
    input  logic                           Clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [WORD_W-1:0]              guess,
    input  logic [WORD_W-1:0]              answer,
    output logic                           busy,
    output logic                           done,
    output logic [N_LETTERS*COLOR_W-1:0]   colors,
    output logic                           win
);

    state_e                         r_state;
    logic [WORD_W-1:0]              r_guess;
    logic [WORD_W-1:0]              r_answer;
    logic [N_LETTERS-1:0]           r_green;
    logic [N_LETTERS-1:0]           r_consumed;
    logic [2:0]                     r_idx;
    logic [N_LETTERS*COLOR_W-1:0]   r_col;
    logic [N_LETTERS*COLOR_W-1:0]   r_colors;
    logic                           r_win;
    logic                           r_done;
    logic                           r_busy;

    logic [N_LETTERS-1:0]           w_green;
    logic                           w_found;
    logic [N_LETTERS-1:0]           w_match_oh;

    always_comb begin
        w_green = '0;
        for (int i = 0; i < N_LETTERS; i++) begin
            w_green[i] = (letter_at(r_guess, 3'(i)) == letter_at(r_answer, 3'(i)));
        end
    end

    wordle_letter_match u_match (
        .i_letter   (letter_at(r_guess, r_idx)),
        .i_answer   (r_answer),
        .i_consumed (r_consumed),
        .o_found    (w_found),
        .o_match_oh (w_match_oh)
    );

    always_ff @(posedge Clk) begin
        if (!reset) begin
            r_state    <= StIdle;
            r_guess    <= '0;
            r_answer   <= '0;
            r_green    <= '0;
            r_consumed <= '0;
            r_idx      <= '0;
            r_col      <= '1;
            r_colors   <= '1;
            r_win      <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_guess    <= guess;
                        r_answer   <= answer;
                        r_green    <= '0;
                        r_consumed <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= StGreen;
                    end
                end
                StGreen: begin
                    // Exact matches claim their answer letters before any yellow search.
                    r_green    <= w_green;
                    r_consumed <= w_green;
                    r_idx      <= '0;
                    r_state    <= StYellow;
                end
                StYellow: begin
                    if (r_green[r_idx]) begin
                        r_col[(N_LETTERS*COLOR_W-1) - (COLOR_W*r_idx) -: COLOR_W] <= COLOR_GREEN;
                    end else if (w_found) begin
                        r_col[(N_LETTERS*COLOR_W-1) - (COLOR_W*r_idx) -: COLOR_W] <= COLOR_YELLOW;
                        r_consumed <= r_consumed | w_match_oh;
                    end else begin
                        r_col[(N_LETTERS*COLOR_W-1) - (COLOR_W*r_idx) -: COLOR_W] <= COLOR_MISS;
                    end
                    if (r_idx == 3'd4) begin
                        r_state <= StDone;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
                StDone: begin
                    r_colors <= r_col;
                    r_win    <= &r_green;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign colors = r_colors;
    assign win    = r_win;

endmodule

// File: tb/tb_wordle_scorer.sv
// Scoreboard bench for wordle_scorer: driver pushes expected results, negedge monitor checks them.
module tb_wordle_scorer;

    logic        Clk;
    logic        reset;
    logic        start;
    logic [39:0] guess;
    logic [39:0] answer;
    logic        busy;
    logic        done;
    logic [14:0] colors;
    logic        win;

    typedef struct packed {
        logic [14:0] colors;
        logic        win;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   checks;
    int   failures;
    int   cyc;
    int   n_done;

    wordle_scorer dut (
        .Clk    (Clk),
        .reset  (reset),
        .start  (start),
        .guess  (guess),
        .answer (answer),
        .busy   (busy),
        .done   (done),
        .colors (colors),
        .win    (win)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [39:0] word(input string s);
        logic [39:0] w = '0;
        for (int i = 0; i < 5; i++) w = {w[31:0], s[i]};
        return w;
    endfunction

    function automatic logic [39:0] rand_word();
        string       al = "ABCE ";
        logic [39:0] w  = '0;
        for (int i = 0; i < 5; i++) w = {w[31:0], al[$urandom_range(0, 4)]};
        return w;
    endfunction

    // Reference scoring from the game rules: greens claim first, then yellows left to right.
    function automatic exp_t model(input logic [39:0] g, input logic [39:0] a);
        byte  gl[5];
        byte  al[5];
        bit   used[5];
        logic [2:0] col[5];
        exp_t e;
        int   n_green = 0;
        for (int i = 0; i < 5; i++) begin
            gl[i] = g[39-8*i -: 8];
            al[i] = a[39-8*i -: 8];
            used[i] = (gl[i] == al[i]);
            col[i] = used[i] ? 3'b010 : 3'b111;
            if (used[i]) n_green++;
        end
        for (int i = 0; i < 5; i++) begin
            if (gl[i] != al[i]) begin
                for (int j = 0; j < 5; j++) begin
                    if (col[i] == 3'b111 && !used[j] && al[j] == gl[i]) begin
                        used[j] = 1'b1;
                        col[i]  = 3'b110;
                    end
                end
            end
        end
        e.colors = {col[0], col[1], col[2], col[3], col[4]};
        e.win    = (n_green == 5);
        e.cyc    = 0;
        return e;
    endfunction

    always @(negedge Clk) begin
        if (reset === 1'b1 && done === 1'b1) begin
            exp_t e;
            n_done++;
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got done=1 want no pending scan (t=%0t)", $time);
            end else begin
                e = q.pop_front();
                check("colors", {17'd0, colors}, {17'd0, e.colors});
                check("win", {31'd0, win}, {31'd0, e.win});
                check("latency_cycle", cyc, e.cyc);
                check("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    // Issues one start; expectation is pushed right after the accepting edge.
    task automatic issue(input logic [39:0] g, input logic [39:0] a, input exp_t e);
        @(negedge Clk);
        guess  = g;
        answer = a;
        start  = 1'b1;
        @(posedge Clk);
        #1;
        e.cyc = cyc + 7;
        q.push_back(e);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n0 = n_done;
        int k  = 0;
        while (n_done == n0 && k < 30) begin
            @(negedge Clk);
            k++;
        end
        if (n_done == n0) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: got no done want done within 30 cycles");
        end
        @(negedge Clk);
    endtask

    function automatic exp_t mk(input logic [14:0] c, input logic w);
        exp_t e;
        e.colors = c;
        e.win    = w;
        e.cyc    = 0;
        return e;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        checks   = 0;
        failures = 0;
        n_done   = 0;
        reset    = 1'b0;
        start    = 1'b0;
        guess    = '0;
        answer   = '0;
        repeat (3) @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_colors", {17'd0, colors}, 32'h7FFF);
        check("rst_win", {31'd0, win}, 32'd0);

        issue(word("CRANE"), word("CRANE"), mk(15'b010_010_010_010_010, 1'b1));
        wait_done();
        issue(word("TOUGH"), word("CRANE"), mk(15'h7FFF, 1'b0));
        wait_done();
        issue(word("PAPER"), word("APPLE"), mk(15'b110_110_010_110_111, 1'b0));
        wait_done();
        issue(word("BBBBB"), word("ABBEY"), mk(15'b111_010_010_111_111, 1'b0));
        wait_done();

        // Starts during GREEN, YELLOW and DONE must be ignored, as must input changes.
        n0 = n_done;
        issue(word("APPLE"), word("PAPER"), model(word("APPLE"), word("PAPER")));
        for (int k = 0; k < 7; k++) begin
            @(negedge Clk);
            if (k == 0) check("busy_in_green", {31'd0, busy}, 32'd1);
            start  = 1'b1;
            guess  = rand_word();
            answer = rand_word();
        end
        @(negedge Clk);
        start = 1'b0;
        repeat (12) @(negedge Clk);
        check("single_done", n_done - n0, 32'd1);
        issue(word("CRANE"), word("CRANE"), mk(15'b010_010_010_010_010, 1'b1));
        wait_done();

        // Reset while scoring letter 2.
        n0 = n_done;
        issue(word("PAPER"), word("APPLE"), mk(15'b110_110_010_110_111, 1'b0));
        repeat (4) @(negedge Clk);
        reset = 1'b0;
        q.delete();
        @(negedge Clk);
        reset = 1'b1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_colors", {17'd0, colors}, 32'h7FFF);
        check("midrst_win", {31'd0, win}, 32'd0);
        repeat (10) @(negedge Clk);
        check("midrst_no_done", n_done - n0, 32'd0);
        issue(word("CRANE"), word("CRANE"), mk(15'b010_010_010_010_010, 1'b1));
        wait_done();

        for (int r = 0; r < 40; r++) begin
            logic [39:0] g = rand_word();
            logic [39:0] a = ($urandom_range(0, 7) == 0) ? g : rand_word();
            issue(g, a, model(g, a));
            wait_done();
        end

        repeat (5) @(negedge Clk);
        check("queue_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
